// File: rtl/mcu_shared_ram_arb.sv
// Shared 4 KB RAM arbiter between the main CPU bus and the 8051 MCU external-RAM
// window; serialises both sides onto one RAM port and raises mailbox interrupts.
module mcu_shared_ram_arb #(
    parameter logic [11:0] MBOX_MCU = 12'hFFF,
    parameter logic [11:0] MBOX_CPU = 12'hFFE
) (
    input  logic        CLK_32M,
    input  logic        reset,
    input  logic        mcu_cs,
    input  logic        mcu_we,
    input  logic [11:0] mcu_addr,
    input  logic [7:0]  mcu_wdata,
    output logic [7:0]  mcu_rdata,
    output logic        mcu_int,
    output logic        mcu_overrun,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_int,
    output logic [11:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_M_ADDR = 3'd1,
        S_M_DATA = 3'd2,
        S_C_ADDR = 3'd3,
        S_C_DATA = 3'd4
    } state_t;

    typedef enum logic {
        G_CPU = 1'b0,
        G_MCU = 1'b1
    } grant_t;

    state_t        state_q, state_d;
    grant_t        last_q, last_d;
    logic          pend_q, pend_d;
    req_t          mreq_q, mreq_d;
    logic          overrun_q, overrun_d;
    logic          cur_we_q, cur_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic [DW-1:0] mcu_rdata_q, mcu_rdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          mcu_int_q, mcu_int_d;
    logic          cpu_int_q, cpu_int_d;

    req_t mcu_live;
    req_t mcu_src;
    logic mcu_want, cpu_want, eval_grant, grant_m, grant_c;

    // State and output registers
    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_q      <= G_CPU;
            pend_q      <= 1'b0;
            mreq_q      <= '0;
            overrun_q   <= 1'b0;
            cur_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            mcu_rdata_q <= '0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            mcu_int_q   <= 1'b0;
            cpu_int_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            pend_q      <= pend_d;
            mreq_q      <= mreq_d;
            overrun_q   <= overrun_d;
            cur_we_q    <= cur_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            mcu_rdata_q <= mcu_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            mcu_int_q   <= mcu_int_d;
            cpu_int_q   <= cpu_int_d;
        end
    end

    // Grant, MCU capture, RAM port sequencing and mailbox flags
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        pend_d      = pend_q;
        mreq_d      = mreq_q;
        overrun_d   = overrun_q;
        cur_we_d    = cur_we_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        mcu_rdata_d = mcu_rdata_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = 1'b0;
        mcu_int_d   = mcu_int_q;
        cpu_int_d   = cpu_int_q;
        grant_m     = 1'b0;
        grant_c     = 1'b0;

        mcu_live = '{we: mcu_we, addr: mcu_addr, wdata: mcu_wdata};
        mcu_src  = pend_q ? mreq_q : mcu_live;
        mcu_want = pend_q | mcu_cs;
        // cpu_req is still held for the access being finished in C_DATA
        cpu_want   = cpu_req & (state_q != S_C_DATA);
        eval_grant = (state_q == S_IDLE) || (state_q == S_M_DATA) || (state_q == S_C_DATA);

        if (eval_grant) begin
            if (mcu_want && cpu_want) begin
                if (last_q == G_CPU) grant_m = 1'b1;
                else                 grant_c = 1'b1;
            end else if (mcu_want) begin
                grant_m = 1'b1;
            end else if (cpu_want) begin
                grant_c = 1'b1;
            end
        end

        if (grant_m) begin
            pend_d = pend_q & mcu_cs;
            if (pend_q && mcu_cs) mreq_d = mcu_live;
        end else if (mcu_cs) begin
            if (pend_q) begin
                overrun_d = 1'b1;
            end else begin
                pend_d = 1'b1;
                mreq_d = mcu_live;
            end
        end

        case (state_q)
            S_M_ADDR: state_d = S_M_DATA;
            S_C_ADDR: state_d = S_C_DATA;
            default:  state_d = grant_m ? S_M_ADDR : (grant_c ? S_C_ADDR : S_IDLE);
        endcase

        if (grant_m) begin
            last_d      = G_MCU;
            cur_we_d    = mcu_src.we;
            ram_addr_d  = mcu_src.addr;
            ram_we_d    = mcu_src.we;
            ram_wdata_d = mcu_src.wdata;
        end else if (grant_c) begin
            last_d      = G_CPU;
            cur_we_d    = cpu_we;
            ram_addr_d  = cpu_addr;
            ram_we_d    = cpu_we;
            ram_wdata_d = cpu_wdata;
        end

        // ram_addr_q still holds the finishing access's address in X_DATA
        if (state_q == S_M_DATA) begin
            if (!cur_we_q) mcu_rdata_d = ram_rdata;
            if (cur_we_q && (ram_addr_q == MBOX_CPU))  cpu_int_d = 1'b1;
            if (!cur_we_q && (ram_addr_q == MBOX_MCU)) mcu_int_d = 1'b0;
        end
        if (state_q == S_C_DATA) begin
            cpu_ack_d = 1'b1;
            if (!cur_we_q) cpu_rdata_d = ram_rdata;
            if (cur_we_q && (ram_addr_q == MBOX_MCU))  mcu_int_d = 1'b1;
            if (!cur_we_q && (ram_addr_q == MBOX_CPU)) cpu_int_d = 1'b0;
        end
    end

    assign mcu_rdata   = mcu_rdata_q;
    assign mcu_int     = mcu_int_q;
    assign mcu_overrun = overrun_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_int     = cpu_int_q;
    assign ram_addr    = ram_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_mcu_shared_ram_arb.sv
// Directed bench for mcu_shared_ram_arb: table of isolated accesses plus
// hand-written arbitration, overrun and reset sequences against a RAM model.
module tb_mcu_shared_ram_arb;
    logic        CLK_32M = 1'b0;
    logic        reset = 1'b1;
    logic        mcu_cs = 1'b0, mcu_we = 1'b0;
    logic [11:0] mcu_addr = '0;
    logic [7:0]  mcu_wdata = '0;
    logic [7:0]  mcu_rdata;
    logic        mcu_int, mcu_overrun;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack, cpu_int;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;

    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    bit   [7:0]  mem [4096];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        is_cpu;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rd;
        logic        mi;
        logic        ci;
    } vec_t;

    vec_t vecs [15];

    mcu_shared_ram_arb dut (
        .CLK_32M(CLK_32M), .reset(reset),
        .mcu_cs(mcu_cs), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
        .mcu_rdata(mcu_rdata), .mcu_int(mcu_int), .mcu_overrun(mcu_overrun),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_int(cpu_int),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 CLK_32M = ~CLK_32M;

    // Byte RAM with one-cycle registered read and a backdoor preload port
    always @(posedge CLK_32M) begin
        if (pre_we)      mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK_32M);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ram_we"},    32'(ram_we),      32'd0);
        check({tag, "_ram_addr"},  32'(ram_addr),    32'd0);
        check({tag, "_ram_wdata"}, 32'(ram_wdata),   32'd0);
        check({tag, "_cpu_ack"},   32'(cpu_ack),     32'd0);
        check({tag, "_cpu_rdata"}, 32'(cpu_rdata),   32'd0);
        check({tag, "_mcu_rdata"}, 32'(mcu_rdata),   32'd0);
        check({tag, "_mcu_int"},   32'(mcu_int),     32'd0);
        check({tag, "_cpu_int"},   32'(cpu_int),     32'd0);
        check({tag, "_overrun"},   32'(mcu_overrun), 32'd0);
    endtask

    // One isolated access from idle: grant at E0, data at E2
    task automatic run_vec(input vec_t v, input string tag);
        if (v.is_cpu) begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wd;
        end else begin
            mcu_cs = 1'b1; mcu_we = v.we; mcu_addr = v.addr; mcu_wdata = v.wd;
        end
        tick();
        mcu_cs = 1'b0;
        check({tag, "_ram_we"},   32'(ram_we),   32'(v.we));
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'(v.addr));
        if (v.we) check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'(v.wd));
        tick();
        check({tag, "_we_pulse"}, 32'(ram_we), 32'd0);
        check({tag, "_ack_early"}, 32'(cpu_ack), 32'd0);
        tick();
        if (v.is_cpu) begin
            check({tag, "_ack"}, 32'(cpu_ack), 32'd1);
            if (!v.we) check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'(v.rd));
            cpu_req = 1'b0;
        end else if (!v.we) begin
            check({tag, "_mcu_rdata"}, 32'(mcu_rdata), 32'(v.rd));
        end
        check({tag, "_mcu_int"}, 32'(mcu_int), 32'(v.mi));
        check({tag, "_cpu_int"}, 32'(cpu_int), 32'(v.ci));
        tick();
        check({tag, "_ack_pulse"}, 32'(cpu_ack), 32'd0);
    endtask

    // Simultaneous requests with last grant = CPU: MCU read first, CPU read after
    task automatic both_mcu_first(input logic [11:0] ma, input logic [7:0] mexp,
                                  input logic [11:0] ca, input logic [7:0] cexp,
                                  input string tag);
        mcu_cs = 1'b1; mcu_we = 1'b0; mcu_addr = ma;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca;
        tick();
        mcu_cs = 1'b0;
        check({tag, "_first_addr"}, 32'(ram_addr), 32'(ma));
        tick();
        tick();
        check({tag, "_mcu_rdata"},   32'(mcu_rdata), 32'(mexp));
        check({tag, "_second_addr"}, 32'(ram_addr),  32'(ca));
        tick();
        check({tag, "_ack_wait"}, 32'(cpu_ack), 32'd0);
        tick();
        check({tag, "_ack"},       32'(cpu_ack),   32'd1);
        check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'(cexp));
        cpu_req = 1'b0;
        tick();
        check({tag, "_ack_pulse"}, 32'(cpu_ack), 32'd0);
    endtask

    // Simultaneous requests with last grant = MCU: CPU read first, MCU 5 cycles
    task automatic both_cpu_first(input logic [11:0] ma, input logic [7:0] mexp,
                                  input logic [7:0] mprev, input logic [11:0] ca,
                                  input logic [7:0] cexp, input string tag);
        mcu_cs = 1'b1; mcu_we = 1'b0; mcu_addr = ma;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca;
        tick();
        mcu_cs = 1'b0;
        check({tag, "_first_addr"}, 32'(ram_addr), 32'(ca));
        tick();
        tick();
        check({tag, "_ack"},       32'(cpu_ack),   32'd1);
        check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'(cexp));
        check({tag, "_second_addr"}, 32'(ram_addr), 32'(ma));
        cpu_req = 1'b0;
        tick();
        check({tag, "_mcu_rdata_old"}, 32'(mcu_rdata), 32'(mprev));
        tick();
        check({tag, "_mcu_rdata"}, 32'(mcu_rdata), 32'(mexp));
    endtask

    initial begin
        //          cpu   we    addr     wd     rd     mi    ci
        vecs[0]  = '{1'b0, 1'b1, 12'h123, 8'hA5, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 12'h123, 8'h00, 8'hA5, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 12'h456, 8'h00, 8'h3C, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 12'h200, 8'h5A, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 12'h200, 8'h00, 8'h5A, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 12'h300, 8'hC3, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 12'h300, 8'h00, 8'hC3, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 12'hFFF, 8'h02, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 12'hFFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 12'hFFF, 8'h00, 8'h01, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 12'hFFE, 8'h77, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 12'hFFE, 8'h78, 8'h00, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 12'hFFE, 8'h00, 8'h78, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 12'h000, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 12'h000, 8'h00, 8'hFF, 1'b0, 1'b0};

        pre_we = 1'b1; pre_addr = 12'h456; pre_data = 8'h3C;
        tick();
        pre_we = 1'b0;
        tick();
        check_zero_outputs("reset0");
        reset = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Make the CPU the last grantee, then race both sides
        run_vec('{1'b1, 1'b0, 12'h456, 8'h00, 8'h3C, 1'b0, 1'b0}, "pre_arb1");
        both_mcu_first(12'h123, 8'hA5, 12'h456, 8'h3C, "arb1");
        run_vec('{1'b0, 1'b0, 12'h200, 8'h00, 8'h5A, 1'b0, 1'b0}, "pre_arb2");
        both_cpu_first(12'h300, 8'hC3, 8'h5A, 12'h456, 8'h3C, "arb2");

        // Overrun: second strobe lands while the first is still pending behind a CPU read
        mcu_cs = 1'b1; mcu_we = 1'b1; mcu_addr = 12'h400; mcu_wdata = 8'h11;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h456;
        tick();
        check("ovr_cpu_first", 32'(ram_addr), 32'h456);
        check("ovr_clear", 32'(mcu_overrun), 32'd0);
        mcu_addr = 12'h401; mcu_wdata = 8'h22;
        tick();
        mcu_cs = 1'b0; mcu_we = 1'b0;
        check("ovr_set", 32'(mcu_overrun), 32'd1);
        tick();
        check("ovr_ack", 32'(cpu_ack), 32'd1);
        check("ovr_cpu_rdata", 32'(cpu_rdata), 32'h3C);
        cpu_req = 1'b0;
        check("ovr_m_we", 32'(ram_we), 32'd1);
        check("ovr_m_addr", 32'(ram_addr), 32'h400);
        check("ovr_m_wdata", 32'(ram_wdata), 32'h11);
        tick();
        tick();
        run_vec('{1'b0, 1'b0, 12'h401, 8'h00, 8'h00, 1'b0, 1'b0}, "ovr_dropped");
        run_vec('{1'b0, 1'b0, 12'h400, 8'h00, 8'h11, 1'b0, 1'b0}, "ovr_kept");
        check("ovr_sticky", 32'(mcu_overrun), 32'd1);

        // Reset in C_ADDR of a CPU write aborts it
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h500; cpu_wdata = 8'h99;
        tick();
        check("rst_c_addr_we", 32'(ram_we), 32'd1);
        reset = 1'b1; cpu_req = 1'b0;
        tick();
        check_zero_outputs("rst_mid");
        tick();
        check("rst_no_ack", 32'(cpu_ack), 32'd0);
        reset = 1'b0;
        both_mcu_first(12'h400, 8'h11, 12'h456, 8'h3C, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
